// File: rtl/logic_function_unit_pkg.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Package  : logic_fn_pkg                                                |
// | Purpose  : Shared constants for the programmable Boolean function unit:|
// |            FSM state encoding, request mode encoding and a table-size  |
// |            helper.                                                     |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
package logic_fn_pkg;

  // FSM state encoding
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_LOOK  = 2'd1;
  localparam logic [1:0] S_SWEEP = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  // Request mode encoding (in_mode)
  localparam logic MODE_LOOKUP = 1'b0;
  localparam logic MODE_SWEEP  = 1'b1;

  // Number of truth-table entries for an n-input function
  function automatic int table_size(input int n);
    return 1 << n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/logic_function_unit_if.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Interface : logic_function_unit_if                                     |
// | Purpose   : Configuration, request and result streams of the Boolean   |
// |             function unit.                                             |
// | Ports     : cfg_load/cfg_table/cfg_ack   table configuration           |
// |             in_valid/in_ready/in_mode/in_vec   request stream          |
// |             out_valid/out_ready/out_vec/out_sop/out_pos/out_last       |
// |                                               result stream            |
// |             cnt_valid/cnt_ones            sweep minterm count          |
// |             form_err                      sticky SoP/PoS disagreement  |
// |             slave modport = unit side, master modport = client side    |
// | Revision  : 1.0  initial release                                       |
// +------------------------------------------------------------------------+
interface logic_function_unit_if #(
  parameter int N_IN = 4
);
  localparam int T = 1 << N_IN;

  logic            cfg_load;
  logic [T-1:0]    cfg_table;
  logic            cfg_ack;

  logic            in_valid;
  logic            in_ready;
  logic            in_mode;
  logic [N_IN-1:0] in_vec;

  logic            out_valid;
  logic            out_ready;
  logic [N_IN-1:0] out_vec;
  logic            out_sop;
  logic            out_pos;
  logic            out_last;

  logic            cnt_valid;
  logic [N_IN:0]   cnt_ones;
  logic            form_err;

  modport slave (
    input  cfg_load, cfg_table, in_valid, in_mode, in_vec, out_ready,
    output cfg_ack, in_ready, out_valid, out_vec, out_sop, out_pos, out_last,
           cnt_valid, cnt_ones, form_err
  );

  modport master (
    output cfg_load, cfg_table, in_valid, in_mode, in_vec, out_ready,
    input  cfg_ack, in_ready, out_valid, out_vec, out_sop, out_pos, out_last,
           cnt_valid, cnt_ones, form_err
  );

endinterface
`default_nettype wire

// File: rtl/logic_function_unit_minterm_eval.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : minterm_eval                                                |
// | Purpose  : Combinational evaluation of a truth table in canonical      |
// |            Sum-of-Products and Product-of-Sums form.                   |
// | Ports    : tbl  in  2^N_IN  truth table, bit i = f(vec == i)           |
// |            vec  in  N_IN    input vector                               |
// |            sop  out 1       OR of selected minterms                    |
// |            pos  out 1       AND of maxterms                            |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module minterm_eval
  import logic_fn_pkg::*;
#(
  parameter int N_IN = 4
) (
  input  wire logic [(1<<N_IN)-1:0] tbl,
  input  wire logic [N_IN-1:0]      vec,
  output logic                      sop,
  output logic                      pos
);

  localparam int T = table_size(N_IN);

  logic [T-1:0] minterm_hit;
  logic [T-1:0] maxterm_ok;

  // The two forms are built from separate term sets so that a fault in
  // either one shows up as an SoP/PoS disagreement.
  for (genvar i = 0; i < T; i++) begin : g_term
    localparam logic [N_IN-1:0] IDX = N_IN'(i);
    assign minterm_hit[i] = tbl[i] & (vec == IDX);
    assign maxterm_ok[i]  = tbl[i] | (vec != IDX);
  end

  assign sop = |minterm_hit;
  assign pos = &maxterm_ok;

endmodule
`default_nettype wire

// File: rtl/logic_function_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : logic_function_unit                                         |
// | Purpose  : Programmable N_IN-input Boolean function evaluator. Holds a |
// |            truth table, serves single lookups and full-input sweeps    |
// |            over valid/ready streams and reports the minterm count of   |
// |            each completed sweep.                                       |
// | Ports    : clk    in  rising-edge clock                                |
// |            reset  in  asynchronous active-high reset                   |
// |            bus    logic_function_unit_if.slave (cfg, request, result,  |
// |                   count and error signals)                             |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module logic_function_unit
  import logic_fn_pkg::*;
#(
  parameter int N_IN = 4
) (
  input wire logic             clk,
  input wire logic             reset,
  logic_function_unit_if.slave bus
);

  localparam int              T        = table_size(N_IN);
  localparam logic [N_IN-1:0] IDX_LAST = {N_IN{1'b1}};
  localparam logic [N_IN-1:0] IDX_ONE  = {{(N_IN-1){1'b0}}, 1'b1};

  logic [1:0]      state_q,     state_d;
  logic [T-1:0]    table_q,     table_d;
  logic [N_IN-1:0] idx_q,       idx_d;
  logic [N_IN:0]   ones_q,      ones_d;
  logic            in_ready_q,  in_ready_d;
  logic            cfg_ack_q,   cfg_ack_d;
  logic            out_valid_q, out_valid_d;
  logic [N_IN-1:0] out_vec_q,   out_vec_d;
  logic            out_sop_q,   out_sop_d;
  logic            out_pos_q,   out_pos_d;
  logic            out_last_q,  out_last_d;
  logic            cnt_valid_q, cnt_valid_d;
  logic [N_IN:0]   cnt_ones_q,  cnt_ones_d;
  logic            form_err_q,  form_err_d;

  logic            cfg_write;
  logic            accept;
  logic [T-1:0]    eval_tbl;
  logic [N_IN-1:0] eval_vec;
  logic            eval_sop;
  logic            eval_pos;
  logic            load;
  logic            load_last;

  // A table write and a request accepted in the same IDLE cycle must see
  // the new table, so the evaluator looks at the incoming table directly.
  assign cfg_write = (state_q == S_IDLE) && bus.cfg_load;
  assign accept    = in_ready_q && bus.in_valid;
  assign eval_tbl  = cfg_write ? bus.cfg_table : table_q;

  // In IDLE the evaluator serves the request being accepted (a sweep starts
  // at vector 0); during a sweep it serves the next index to be emitted.
  always_comb begin
    eval_vec = idx_q;
    if (state_q == S_IDLE) begin
      eval_vec = (bus.in_mode == MODE_SWEEP) ? '0 : bus.in_vec;
    end
  end

  minterm_eval #(
    .N_IN (N_IN)
  ) u_eval (
    .tbl (eval_tbl),
    .vec (eval_vec),
    .sop (eval_sop),
    .pos (eval_pos)
  );

  always_comb begin
    state_d     = state_q;
    table_d     = eval_tbl;
    idx_d       = idx_q;
    ones_d      = ones_q;
    cfg_ack_d   = cfg_write;
    out_valid_d = out_valid_q;
    out_vec_d   = out_vec_q;
    out_sop_d   = out_sop_q;
    out_pos_d   = out_pos_q;
    out_last_d  = out_last_q;
    cnt_valid_d = 1'b0;
    cnt_ones_d  = cnt_ones_q;
    form_err_d  = form_err_q;
    load        = 1'b0;
    load_last   = 1'b0;

    // Result consumed; a load below may refill the register in the same cycle.
    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    case (state_q)
      S_IDLE: begin
        if (accept) begin
          load = 1'b1;
          if (bus.in_mode == MODE_SWEEP) begin
            // Vector 0 goes out on acceptance so the first result appears
            // one cycle later; the sweep continues from index 1.
            idx_d   = IDX_ONE;
            ones_d  = {{N_IN{1'b0}}, eval_sop};
            state_d = S_SWEEP;
          end else begin
            load_last = 1'b1;
            state_d   = S_LOOK;
          end
        end
      end

      S_LOOK: begin
        state_d = S_IDLE;
      end

      S_SWEEP: begin
        if (!out_valid_q || bus.out_ready) begin
          load      = 1'b1;
          load_last = (idx_q == IDX_LAST);
          ones_d    = ones_q + {{N_IN{1'b0}}, eval_sop};
          if (idx_q == IDX_LAST) begin
            state_d = S_DONE;
          end else begin
            idx_d = idx_q + IDX_ONE;
          end
        end
      end

      S_DONE: begin
        if (out_valid_q && bus.out_ready) begin
          cnt_ones_d  = ones_q;
          cnt_valid_d = 1'b1;
          state_d     = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (load) begin
      out_valid_d = 1'b1;
      out_vec_d   = eval_vec;
      out_sop_d   = eval_sop;
      out_pos_d   = eval_pos;
      out_last_d  = load_last;
      if (eval_sop != eval_pos) begin
        form_err_d = 1'b1;
      end
    end

    // Registered so that it stays low through reset and rises on the first
    // edge after release.
    in_ready_d = (state_d == S_IDLE) && !out_valid_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_IDLE;
      table_q     <= '0;
      idx_q       <= '0;
      ones_q      <= '0;
      in_ready_q  <= 1'b0;
      cfg_ack_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_vec_q   <= '0;
      out_sop_q   <= 1'b0;
      out_pos_q   <= 1'b0;
      out_last_q  <= 1'b0;
      cnt_valid_q <= 1'b0;
      cnt_ones_q  <= '0;
      form_err_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      table_q     <= table_d;
      idx_q       <= idx_d;
      ones_q      <= ones_d;
      in_ready_q  <= in_ready_d;
      cfg_ack_q   <= cfg_ack_d;
      out_valid_q <= out_valid_d;
      out_vec_q   <= out_vec_d;
      out_sop_q   <= out_sop_d;
      out_pos_q   <= out_pos_d;
      out_last_q  <= out_last_d;
      cnt_valid_q <= cnt_valid_d;
      cnt_ones_q  <= cnt_ones_d;
      form_err_q  <= form_err_d;
    end
  end

  assign bus.in_ready  = in_ready_q;
  assign bus.cfg_ack   = cfg_ack_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_vec   = out_vec_q;
  assign bus.out_sop   = out_sop_q;
  assign bus.out_pos   = out_pos_q;
  assign bus.out_last  = out_last_q;
  assign bus.cnt_valid = cnt_valid_q;
  assign bus.cnt_ones  = cnt_ones_q;
  assign bus.form_err  = form_err_q;

endmodule
`default_nettype wire

// File: tb/tb_logic_function_unit.sv
`default_nettype none
// +------------------------------------------------------------------------+
// | Module   : tb_logic_function_unit                                      |
// | Purpose  : Self-checking bench for logic_function_unit (N_IN = 4 and   |
// |            N_IN = 2 instances) against a truth-table reference model.  |
// | Revision : 1.0  initial release                                        |
// +------------------------------------------------------------------------+
module tb_logic_function_unit;
  import logic_fn_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic_function_unit_if #(.N_IN(4)) a ();
  logic_function_unit_if #(.N_IN(2)) b ();

  logic_function_unit #(.N_IN(4)) dut4 (.clk(clk), .reset(reset), .bus(a));
  logic_function_unit #(.N_IN(2)) dut2 (.clk(clk), .reset(reset), .bus(b));

  int checks = 0;
  int errors = 0;

  // Reference model: the truth table each instance is expected to hold.
  logic [15:0] model4;
  logic [3:0]  model2;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_ready4(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (a.in_ready === 1'b1) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL in_ready_timeout: in_ready=%b required 1", a.in_ready);
    end
  endtask

  task automatic cfg4(input logic [15:0] tbl);
    a.cfg_load  = 1'b1;
    a.cfg_table = tbl;
    tick();
    a.cfg_load = 1'b0;
    model4     = tbl;
    checks++;
    if (a.cfg_ack !== 1'b1) begin
      errors++;
      $display("FAIL cfg_ack: got %b required 1", a.cfg_ack);
    end
    tick();
    checks++;
    if (a.cfg_ack !== 1'b0) begin
      errors++;
      $display("FAIL cfg_ack_pulse: got %b required 0", a.cfg_ack);
    end
  endtask

  task automatic lookup4(input logic [3:0] v, input bit do_cfg, input logic [15:0] new_tbl);
    bit ok;
    logic [7:0] exp;
    wait_ready4(ok);
    if (!ok) return;
    a.in_valid  = 1'b1;
    a.in_mode   = MODE_LOOKUP;
    a.in_vec    = v;
    a.out_ready = 1'b0;
    if (do_cfg) begin
      a.cfg_load  = 1'b1;
      a.cfg_table = new_tbl;
      model4      = new_tbl;
    end
    tick();
    a.in_valid = 1'b0;
    a.cfg_load = 1'b0;
    a.in_vec   = 4'($urandom);
    exp = {1'b1, v, model4[v], model4[v], 1'b1};
    if (do_cfg) begin
      checks++;
      if (a.cfg_ack !== 1'b1) begin
        errors++;
        $display("FAIL lookup_cfg_ack: got %b required 1", a.cfg_ack);
      end
    end
    checks++;
    if ({a.out_valid, a.out_vec, a.out_sop, a.out_pos, a.out_last} !== exp) begin
      errors++;
      $display("FAIL lookup_result vec=%h: got %b required %b", v,
               {a.out_valid, a.out_vec, a.out_sop, a.out_pos, a.out_last}, exp);
    end
    tick();
    checks++;
    if ({a.out_valid, a.out_vec, a.out_sop, a.out_pos, a.out_last, a.in_ready} !== {exp, 1'b0}) begin
      errors++;
      $display("FAIL lookup_hold: got %b required %b",
               {a.out_valid, a.out_vec, a.out_sop, a.out_pos, a.out_last, a.in_ready}, {exp, 1'b0});
    end
    a.out_ready = 1'b1;
    tick();
    a.out_ready = 1'b0;
    checks++;
    if ({a.out_valid, a.in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL lookup_drain: out_valid,in_ready got %b required 01", {a.out_valid, a.in_ready});
    end
  endtask

  // rmode: 0 = out_ready always 1, 1 = toggle 1/0, 2 = random.
  // cfg_mid: attempt a table write of zeros part-way through the sweep.
  task automatic sweep4(input int rmode, input bit cfg_mid);
    bit ok;
    int got;
    int pulses;
    bit ready;
    bit stalled;
    logic [7:0] prev;
    logic [7:0] obs;
    logic [7:0] exp;
    logic [3:0] idx;
    logic [4:0] exp_ones;
    got = 0;
    pulses = 0;
    stalled = 1'b0;
    prev = '0;
    exp_ones = 5'($countones(model4));
    wait_ready4(ok);
    if (!ok) return;
    a.in_valid  = 1'b1;
    a.in_mode   = MODE_SWEEP;
    a.in_vec    = 4'($urandom);
    a.out_ready = 1'b0;
    tick();
    a.in_valid = 1'b0;
    for (int cyc = 0; cyc < 200; cyc++) begin
      obs = {a.out_valid, a.out_vec, a.out_sop, a.out_pos, a.out_last};
      if (cyc == 0) begin
        checks++;
        if (a.out_valid !== 1'b1) begin
          errors++;
          $display("FAIL sweep_first_latency: out_valid=%b required 1", a.out_valid);
        end
      end
      if (a.cnt_valid === 1'b1) begin
        pulses++;
        checks++;
        if (got != 16 || a.cnt_ones !== exp_ones) begin
          errors++;
          $display("FAIL sweep_cnt: cnt_ones=%0d after %0d results, required %0d after 16",
                   a.cnt_ones, got, exp_ones);
        end
      end
      if (stalled) begin
        checks++;
        if (obs !== prev) begin
          errors++;
          $display("FAIL sweep_hold: got %b required %b", obs, prev);
        end
      end
      if (cfg_mid) begin
        checks++;
        if (a.cfg_ack !== 1'b0) begin
          errors++;
          $display("FAIL cfg_mid_ack: got %b required 0", a.cfg_ack);
        end
      end
      if (got == 16 && pulses > 0) break;
      case (rmode)
        0:       ready = 1'b1;
        1:       ready = (cyc % 2 == 0);
        default: ready = 1'($urandom);
      endcase
      a.out_ready = ready;
      a.cfg_load  = cfg_mid && (cyc == 5);
      if (cfg_mid) a.cfg_table = 16'h0000;
      if (a.out_valid === 1'b1 && ready) begin
        idx = 4'(got);
        exp = {1'b1, idx, model4[idx], model4[idx], (got == 15)};
        checks++;
        if (obs !== exp || got >= 16 || (rmode == 0 && got != cyc)) begin
          errors++;
          $display("FAIL sweep_result #%0d cyc %0d: got %b required %b", got, cyc, obs, exp);
        end
        got++;
      end
      stalled = (a.out_valid === 1'b1) && !ready;
      prev = obs;
      tick();
    end
    a.out_ready = 1'b0;
    a.cfg_load  = 1'b0;
    checks++;
    if (got != 16 || pulses != 1) begin
      errors++;
      $display("FAIL sweep_total: results=%0d pulses=%0d required 16 and 1", got, pulses);
    end
    tick();
    checks++;
    if (a.cnt_valid !== 1'b0 || a.cnt_ones !== exp_ones || a.form_err !== 1'b0) begin
      errors++;
      $display("FAIL sweep_after: cnt_valid=%b cnt_ones=%0d form_err=%b required 0 %0d 0",
               a.cnt_valid, a.cnt_ones, a.form_err, exp_ones);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) tick();
    checks++;
    if ({a.in_ready, a.cfg_ack, a.out_valid, a.out_vec, a.out_sop, a.out_pos, a.out_last,
         a.cnt_valid, a.cnt_ones, a.form_err} !== 17'd0) begin
      errors++;
      $display("FAIL reset_outputs: got %b required 0",
               {a.in_ready, a.cfg_ack, a.out_valid, a.out_vec, a.out_sop, a.out_pos, a.out_last,
                a.cnt_valid, a.cnt_ones, a.form_err});
    end
    reset = 1'b0;
    model4 = '0;
    model2 = '0;
    tick();
    checks++;
    if (a.in_ready !== 1'b1 || b.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_release_ready: got %b%b required 11", a.in_ready, b.in_ready);
    end
  endtask

  task automatic test_lookup_basic();
    lookup4(4'h5, 1'b0, 16'h0);   // table is zero out of reset
    cfg4(16'hFFFE);
    lookup4(4'h0, 1'b0, 16'h0);
    lookup4(4'h9, 1'b0, 16'h0);
  endtask

  task automatic test_sweep_full();
    sweep4(0, 1'b0);
  endtask

  task automatic test_stall();
    cfg4(16'h8421);
    sweep4(1, 1'b0);
  endtask

  task automatic test_cfg_mid();
    sweep4(2, 1'b1);
    cfg4(16'h0000);
    lookup4(4'($urandom), 1'b0, 16'h0);
  endtask

  task automatic test_reset_mid();
    bit found;
    bit saw_cnt;
    cfg4(16'hA5F3);
    a.in_valid  = 1'b1;
    a.in_mode   = MODE_SWEEP;
    a.out_ready = 1'b1;
    found = 1'b0;
    for (int k = 0; k < 40; k++) begin
      tick();
      a.in_valid = 1'b0;
      if (a.out_valid === 1'b1 && a.out_vec === 4'h7) begin
        found = 1'b1;
        break;
      end
    end
    checks++;
    if (!found) begin
      errors++;
      $display("FAIL reset_mid_reach: out_vec=%h required 7", a.out_vec);
    end
    reset = 1'b1;
    #1;
    checks++;
    if ({a.in_ready, a.cfg_ack, a.out_valid, a.out_vec, a.out_sop, a.out_pos, a.out_last,
         a.cnt_valid, a.cnt_ones, a.form_err} !== 17'd0) begin
      errors++;
      $display("FAIL reset_mid_async: got %b required 0",
               {a.in_ready, a.cfg_ack, a.out_valid, a.out_vec, a.out_sop, a.out_pos, a.out_last,
                a.cnt_valid, a.cnt_ones, a.form_err});
    end
    tick();
    tick();
    reset = 1'b0;
    model4 = '0;
    model2 = '0;
    saw_cnt = 1'b0;
    tick();
    checks++;
    if (a.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_mid_ready: got %b required 1", a.in_ready);
    end
    for (int k = 0; k < 20; k++) begin
      if (a.cnt_valid === 1'b1) saw_cnt = 1'b1;
      tick();
    end
    checks++;
    if (saw_cnt || a.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_mid_quiet: cnt_valid seen=%b out_valid=%b required 0 0", saw_cnt, a.out_valid);
    end
    a.out_ready = 1'b0;
    lookup4(4'hF, 1'b0, 16'h0);   // bit F of the pre-reset table was 1
  endtask

  task automatic test_n2();
    bit ok;
    int got;
    bit done;
    b.cfg_load  = 1'b1;
    b.cfg_table = 4'b0110;
    tick();
    b.cfg_load = 1'b0;
    model2     = 4'b0110;
    checks++;
    if (b.cfg_ack !== 1'b1) begin
      errors++;
      $display("FAIL n2_cfg_ack: got %b required 1", b.cfg_ack);
    end
    b.in_valid  = 1'b1;
    b.in_mode   = MODE_SWEEP;
    b.out_ready = 1'b1;
    tick();
    b.in_valid = 1'b0;
    got  = 0;
    done = 1'b0;
    for (int k = 0; k < 20 && !done; k++) begin
      if (b.cnt_valid === 1'b1) begin
        done = 1'b1;
        checks++;
        if (b.cnt_ones !== 3'(2) || got != 4) begin
          errors++;
          $display("FAIL n2_cnt: cnt_ones=%0d results=%0d required 2 and 4", b.cnt_ones, got);
        end
      end else if (b.out_valid === 1'b1) begin
        checks++;
        if (got >= 4 || b.out_vec !== 2'(got) || b.out_sop !== model2[2'(got)] ||
            b.out_last !== (got == 3)) begin
          errors++;
          $display("FAIL n2_sweep #%0d: vec=%0d sop=%b last=%b required %0d %b %b", got,
                   b.out_vec, b.out_sop, b.out_last, got, model2[2'(got)], (got == 3));
        end
        got++;
      end
      if (!done) tick();
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL n2_timeout: results=%0d cnt_valid never seen, required pulse", got);
    end
    b.out_ready = 1'b0;
    tick();
    ok = (b.in_ready === 1'b1);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL n2_ready: got %b required 1", b.in_ready);
    end
    b.cfg_load  = 1'b1;
    b.cfg_table = 4'b1111;
    b.in_valid  = 1'b1;
    b.in_mode   = MODE_LOOKUP;
    b.in_vec    = 2'b00;
    model2      = 4'b1111;
    tick();
    b.cfg_load = 1'b0;
    b.in_valid = 1'b0;
    checks++;
    if ({b.out_valid, b.out_sop, b.out_pos, b.out_last, b.cfg_ack} !== 5'b11111) begin
      errors++;
      $display("FAIL n2_cfg_and_lookup: got %b required 11111",
               {b.out_valid, b.out_sop, b.out_pos, b.out_last, b.cfg_ack});
    end
    b.out_ready = 1'b1;
    tick();
    b.out_ready = 1'b0;
  endtask

  task automatic test_random();
    for (int r = 0; r < 5; r++) begin
      cfg4(16'($urandom));
      for (int j = 0; j < 4; j++) begin
        lookup4(4'($urandom), ($urandom % 3) == 0, 16'($urandom));
      end
      sweep4(2, 1'b0);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL global_timeout: simulation did not complete, required completion");
    $fatal(1, "timeout");
  end

  initial begin
    reset       = 1'b1;
    a.cfg_load  = 1'b0;
    a.cfg_table = '0;
    a.in_valid  = 1'b0;
    a.in_mode   = 1'b0;
    a.in_vec    = '0;
    a.out_ready = 1'b0;
    b.cfg_load  = 1'b0;
    b.cfg_table = '0;
    b.in_valid  = 1'b0;
    b.in_mode   = 1'b0;
    b.in_vec    = '0;
    b.out_ready = 1'b0;
    model4      = '0;
    model2      = '0;

    test_reset();
    test_lookup_basic();
    test_sweep_full();
    test_stall();
    test_cfg_mid();
    test_reset_mid();
    test_n2();
    test_random();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
